// File: rtl/bp_me_stream_dst_router.sv
`default_nettype none
// ============================================================================
//  Module   : bp_me_stream_dst_router
//  Purpose  : Registered stream stage that tags each BedRock message with the
//             xbar sink index decoded from its header address. Optional
//             unmapped-message counter: BP_ME_STREAM_ROUTER_UNMAPPED_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================

package bp_me_stream_dst_router_pkg;

    typedef enum logic [3:0] {
        e_bp_default_cfg    = 4'd0,
        e_bp_half_paddr_cfg = 4'd1
    } bp_params_e;

    function automatic int paddr_width_of(input bp_params_e cfg);
        case (cfg)
            e_bp_half_paddr_cfg: return 20;
            default:             return 40;
        endcase
    endfunction

endpackage

module bp_me_stream_dst_router
    import bp_me_stream_dst_router_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    // Width/count parameters below are always overridden by the instantiating level
    parameter int         data_width_p    = 64,
    parameter int         payload_width_p = 32,
    parameter int         num_sink_p      = 2,
    parameter int         default_sink_p  = 0,
    localparam int        paddr_width_p        = paddr_width_of(bp_params_p),
    localparam int        lg_num_sink_lp       = (num_sink_p > 1) ? $clog2(num_sink_p) : 1,
    // Header layout, LSB first: msg_type[3:0], subop[3:0], addr, size[2:0], payload
    localparam int        xbar_header_width_lp = payload_width_p + 3 + paddr_width_p + 8
)(
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_sink_p*paddr_width_p-1:0]    sink_base_i,
    input  logic [num_sink_p*paddr_width_p-1:0]    sink_mask_i,
    input  logic [xbar_header_width_lp-1:0]        msg_header_i,
    input  logic [data_width_p-1:0]                msg_data_i,
    input  logic                                   msg_v_i,
    output logic                                   msg_ready_and_o,
    input  logic                                   msg_last_i,
    output logic [xbar_header_width_lp-1:0]        msg_header_o,
    output logic [data_width_p-1:0]                msg_data_o,
    output logic                                   msg_v_o,
    input  logic                                   msg_ready_and_i,
    output logic                                   msg_last_o,
    output logic [lg_num_sink_lp-1:0]              msg_dst_o
`ifdef BP_ME_STREAM_ROUTER_UNMAPPED_CNT_EN
  , output logic [15:0]                            unmapped_cnt_o
`endif
);

    localparam int c_addr_lsb = 8;

    typedef enum logic [0:0] {
        e_ready  = 1'b0,
        e_stream = 1'b1
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [lg_num_sink_lp-1:0] r_dst;
    logic [lg_num_sink_lp-1:0] w_hit_idx;
    logic [lg_num_sink_lp-1:0] w_route_dst;
    logic [lg_num_sink_lp-1:0] w_beat_dst;
    logic                      w_hit;
    logic                      w_accept;
    logic                      w_header_accept;
    logic [paddr_width_p-1:0]  w_addr;

    // Single output register: a new beat may enter whenever the slot is empty or draining
    assign msg_ready_and_o = reset_i & (~msg_v_o | msg_ready_and_i);
    assign w_accept        = msg_v_i & msg_ready_and_o;
    assign w_header_accept = w_accept & (r_state == e_ready);
    assign w_addr          = msg_header_i[c_addr_lsb +: paddr_width_p];

    // Scan downward so the lowest matching sink is the one left standing
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = num_sink_p - 1; i >= 0; i--) begin
            if ((w_addr & sink_mask_i[i*paddr_width_p +: paddr_width_p]) ==
                (sink_base_i[i*paddr_width_p +: paddr_width_p] &
                 sink_mask_i[i*paddr_width_p +: paddr_width_p])) begin
                w_hit     = 1'b1;
                w_hit_idx = lg_num_sink_lp'(i);
            end
        end
    end

    assign w_route_dst = w_hit ? w_hit_idx : lg_num_sink_lp'(default_sink_p);
    assign w_beat_dst  = (r_state == e_ready) ? w_route_dst : r_dst;

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                e_ready:  if (!msg_last_i) w_state_next = e_stream;
                e_stream: if (msg_last_i)  w_state_next = e_ready;
                default:  w_state_next = e_ready;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= e_ready;
            r_dst   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_header_accept) begin
                r_dst <= w_route_dst;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            msg_v_o    <= 1'b0;
            msg_last_o <= 1'b0;
            msg_dst_o  <= '0;
        end else begin
            if (msg_ready_and_o) begin
                msg_v_o <= msg_v_i;
            end
            if (w_accept) begin
                msg_last_o <= msg_last_i;
                msg_dst_o  <= w_beat_dst;
            end
        end
    end

    // Payload registers carry no reset; msg_v_o qualifies them
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            msg_header_o <= msg_header_i;
            msg_data_o   <= msg_data_i;
        end
    end

`ifdef BP_ME_STREAM_ROUTER_UNMAPPED_CNT_EN
    logic [15:0] r_unmapped_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_unmapped_cnt <= '0;
        end else if (w_header_accept && !w_hit && (r_unmapped_cnt != 16'hFFFF)) begin
            r_unmapped_cnt <= r_unmapped_cnt + 16'd1;
        end
    end

    assign unmapped_cnt_o = r_unmapped_cnt;
`endif

endmodule

`default_nettype wire
